// File: rtl/spdif_word_gen_if.sv
// spdif_word_gen_if: sample-pair input handshake and subframe-word output
// channel of spdif_word_gen.
//   master : sample source / biphase coder side (drives samples and acks)
//   slave  : word generator side (drives ready and the presented word)
interface spdif_word_gen_if;
  logic [23:0] in_l;
  logic [23:0] in_r;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  word_preamble;
  logic [26:0] word_payload;
  logic        word_ack;

  modport master (
    output in_l, in_r, in_valid, word_ack,
    input  in_ready, word_preamble, word_payload
  );

  modport slave (
    input  in_l, in_r, in_valid, word_ack,
    output in_ready, word_preamble, word_payload
  );
endinterface

// File: rtl/spdif_word_gen.sv
// spdif_word_gen: builds SPDIF subframe words (preamble code + audio/V/U/C)
// from stereo sample pairs and tracks the 192-frame channel-status block.
// Optional feature macro: SPDIF_WORD_GEN_CRC_EN -- when defined, frames
// 184..191 carry the AES3 byte-23 CRCC of C bits 0..183; otherwise they
// carry C=0 and no CRC logic is built.
module spdif_word_gen (
  input  logic               clk,
  input  logic               rst,
  spdif_word_gen_if.slave    bus,
  input  logic [31:0]        cs_cfg,
  output logic               stat_underrun,
  output logic               stat_block
);

  typedef enum logic {
    S_PRIME,
    S_RUN
  } state_e;

  localparam logic [7:0] LAST_FRAME = 8'd191;

  state_e      state_q, state_d;
  logic        sub_q, sub_d;
  logic [7:0]  frame_q, frame_d;
  logic        hold_full_q, hold_full_d;
  logic [23:0] hold_l_q, hold_l_d;
  logic [23:0] hold_r_q, hold_r_d;
  logic [23:0] right_q, right_d;
  logic        right_v_q, right_v_d;
  logic        c_q, c_d;
  logic [31:0] cs_snap_q, cs_snap_d;
  logic [1:0]  preamble_q, preamble_d;
  logic [26:0] payload_q, payload_d;
  logic        in_ready_q, in_ready_d;
  logic        underrun_q, underrun_d;
  logic        block_q, block_d;

  logic        accept;
  logic        build_left;
  logic        build_right;
  logic [7:0]  left_frame;
  logic        c_bit;

`ifdef SPDIF_WORD_GEN_CRC_EN
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  crc_base;
  logic        crc_fb;
`endif

  assign bus.in_ready      = in_ready_q;
  assign bus.word_preamble = preamble_q;
  assign bus.word_payload  = payload_q;
  assign stat_underrun     = underrun_q;
  assign stat_block        = block_q;

  // Next-state: word building on PRIME/ack, holding-slot fill/drain, CRC.
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    frame_d     = frame_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    right_d     = right_q;
    right_v_d   = right_v_q;
    c_d         = c_q;
    cs_snap_d   = cs_snap_q;
    preamble_d  = preamble_q;
    payload_d   = payload_q;
    underrun_d  = 1'b0;
    block_d     = 1'b0;
    build_left  = 1'b0;
    build_right = 1'b0;
    left_frame  = frame_q;
    c_bit       = 1'b0;
`ifdef SPDIF_WORD_GEN_CRC_EN
    crc_d       = crc_q;
    crc_base    = crc_q;
    crc_fb      = 1'b0;
`endif

    accept = bus.in_valid & in_ready_q;

    case (state_q)
      S_PRIME: begin
        build_left = 1'b1;
        left_frame = 8'd0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (bus.word_ack) begin
          if (!sub_q) begin
            build_right = 1'b1;
          end else begin
            build_left = 1'b1;
            left_frame = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
          end
        end
      end
      default: state_d = S_PRIME;
    endcase

    // C bit of the frame about to be built; frame 0 uses cs_cfg directly
    // because cs_snap only picks it up at this same edge.
    if (left_frame == 8'd0) begin
      c_bit = cs_cfg[0];
    end else if (left_frame < 8'd32) begin
      c_bit = cs_snap_q[left_frame[4:0]];
    end else if (left_frame >= 8'd184) begin
`ifdef SPDIF_WORD_GEN_CRC_EN
      c_bit = crc_q[left_frame[2:0]];
`else
      c_bit = 1'b0;
`endif
    end

    if (build_left) begin
      frame_d = left_frame;
      sub_d   = 1'b0;
      c_d     = c_bit;
      if (left_frame == 8'd0) begin
        cs_snap_d  = cs_cfg;
        block_d    = 1'b1;
        preamble_d = 2'b00;
      end else begin
        preamble_d = 2'b10;
      end
      if (hold_full_q) begin
        payload_d   = {c_bit, 1'b0, 1'b0, hold_l_q};
        right_d     = hold_r_q;
        right_v_d   = 1'b0;
        hold_full_d = 1'b0;
      end else begin
        payload_d  = {c_bit, 1'b0, 1'b1, 24'h000000};
        right_d    = '0;
        right_v_d  = 1'b1;
        underrun_d = 1'b1;
      end
`ifdef SPDIF_WORD_GEN_CRC_EN
      // Restart from all-ones at frame 0; fold in each emitted C bit up to 183.
      if (left_frame < 8'd184) begin
        crc_base = (left_frame == 8'd0) ? 8'hFF : crc_q;
        crc_fb   = c_bit ^ crc_base[7];
        crc_d    = {crc_base[6:0], 1'b0} ^ (crc_fb ? 8'h1D : 8'h00);
      end
`endif
    end

    if (build_right) begin
      sub_d      = 1'b1;
      preamble_d = 2'b11;
      payload_d  = {c_q, 1'b0, right_v_q, right_q};
    end

    // Ready is low whenever the slot is full, so accept never meets a pop.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = bus.in_l;
      hold_r_d    = bus.in_r;
    end

    in_ready_d = ~hold_full_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PRIME;
      sub_q       <= 1'b0;
      frame_q     <= '0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      right_q     <= '0;
      right_v_q   <= 1'b0;
      c_q         <= 1'b0;
      cs_snap_q   <= '0;
      preamble_q  <= 2'b00;
      payload_q   <= 27'h1000000;
      in_ready_q  <= 1'b0;
      underrun_q  <= 1'b0;
      block_q     <= 1'b0;
`ifdef SPDIF_WORD_GEN_CRC_EN
      crc_q       <= '1;
`endif
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      frame_q     <= frame_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      right_q     <= right_d;
      right_v_q   <= right_v_d;
      c_q         <= c_d;
      cs_snap_q   <= cs_snap_d;
      preamble_q  <= preamble_d;
      payload_q   <= payload_d;
      in_ready_q  <= in_ready_d;
      underrun_q  <= underrun_d;
      block_q     <= block_d;
`ifdef SPDIF_WORD_GEN_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_spdif_word_gen.sv
// tb_spdif_word_gen: randomized stimulus for spdif_word_gen with a
// word-index/array reference model feeding a scoreboard queue; a monitor
// pops one expected output set per clock and compares it with the DUT.
module tb_spdif_word_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cs_cfg;
  logic        stat_underrun;
  logic        stat_block;

  spdif_word_gen_if bus ();

  spdif_word_gen dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .cs_cfg        (cs_cfg),
    .stat_underrun (stat_underrun),
    .stat_block    (stat_block)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        und;
    logic        blk;
    logic [1:0]  pre;
    logic [26:0] pay;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  // Reference model: word index 0..383 within the block, holding slot as a
  // queue, and the whole block's C bits precomputed at frame 0.
  bit          m_started;
  int          m_widx;
  logic [47:0] m_slot[$];
  logic [23:0] m_r;
  logic        m_rv;
  logic        m_cbits[192];
  logic        m_ready;
  logic        m_und;
  logic        m_blk;
  logic [1:0]  m_pre;
  logic [26:0] m_pay;

  function automatic void chk(string name, logic [26:0] act, logic [26:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h at t=%0t (word %0d)", name, act, exp, $time, m_widx);
  endfunction

  function automatic void load_block(logic [31:0] cfg);
    logic [7:0] crc;
    logic       fb;
    for (int i = 0; i < 192; i++) m_cbits[i] = (i < 32) ? cfg[i] : 1'b0;
    crc = 8'hFF;
    fb  = 1'b0;
`ifdef SPDIF_WORD_GEN_CRC_EN
    for (int i = 0; i < 184; i++) begin
      fb  = m_cbits[i] ^ crc[7];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
    end
    for (int k = 0; k < 8; k++) m_cbits[184 + k] = crc[k];
`endif
  endfunction

  function automatic void build_left(int f, logic [31:0] cfg);
    logic [47:0] p;
    if (f == 0) begin
      load_block(cfg);
      m_blk = 1'b1;
    end
    if (m_slot.size() > 0) begin
      p     = m_slot.pop_front();
      m_pay = {m_cbits[f], 1'b0, 1'b0, p[47:24]};
      m_r   = p[23:0];
      m_rv  = 1'b0;
    end else begin
      m_pay = {m_cbits[f], 1'b0, 1'b1, 24'h000000};
      m_r   = 24'h000000;
      m_rv  = 1'b1;
      m_und = 1'b1;
    end
    m_pre = (f == 0) ? 2'b00 : 2'b10;
  endfunction

  function automatic void build_right(int f);
    m_pay = {m_cbits[f], 1'b0, m_rv, m_r};
    m_pre = 2'b11;
  endfunction

  function automatic void model_step(logic r_, logic a, logic v, logic [23:0] l,
                                     logic [23:0] rr, logic [31:0] cfg);
    exp_t e;
    logic acc;
    if (r_) begin
      m_started = 1'b0;
      m_widx    = 0;
      m_slot.delete();
      m_ready   = 1'b0;
      m_und     = 1'b0;
      m_blk     = 1'b0;
      m_pre     = 2'b00;
      m_pay     = 27'h1000000;
      m_r       = 24'h000000;
      m_rv      = 1'b1;
    end else begin
      acc   = v && m_ready;
      m_und = 1'b0;
      m_blk = 1'b0;
      if (!m_started) begin
        m_started = 1'b1;
        m_widx    = 0;
        build_left(0, cfg);
      end else if (a) begin
        m_widx = (m_widx + 1) % 384;
        if (m_widx % 2 == 1) build_right(m_widx / 2);
        else                 build_left(m_widx / 2, cfg);
      end
      if (acc) m_slot.push_back({l, rr});
      m_ready = (m_slot.size() == 0);
    end
    e.ready = m_ready;
    e.und   = m_und;
    e.blk   = m_blk;
    e.pre   = m_pre;
    e.pay   = m_pay;
    expq.push_back(e);
  endfunction

  // Drive one cycle of inputs, record the expected outputs after the edge.
  task automatic tick(input logic a, input logic v, input logic [23:0] l, input logic [23:0] r);
    bus.word_ack = a;
    bus.in_valid = v;
    bus.in_l     = l;
    bus.in_r     = r;
    model_step(rst, a, v, l, r, cs_cfg);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected output set per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!stim_done) begin
        if (expq.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_underflow: actual empty required entry at t=%0t", $time);
        end else begin
          e = expq.pop_front();
          chk("in_ready",      {26'd0, bus.in_ready},  {26'd0, e.ready});
          chk("stat_underrun", {26'd0, stat_underrun}, {26'd0, e.und});
          chk("stat_block",    {26'd0, stat_block},    {26'd0, e.blk});
          chk("word_preamble", {25'd0, bus.word_preamble}, {25'd0, e.pre});
          chk("word_payload",  bus.word_payload, e.pay);
        end
      end
    end
  end

  initial begin
    int guard;
    cs_cfg       = 32'h0;
    bus.word_ack = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_l     = '0;
    bus.in_r     = '0;

    // Reset, then PRIME and four acks with no input (all underrun/V=1).
    repeat (3) tick(1'b0, 1'b0, 24'h0, 24'h0);
    rst = 1'b0;
    repeat (2) tick(1'b0, 1'b0, 24'h0, 24'h0);
    repeat (4) begin
      tick(1'b1, 1'b0, 24'h0, 24'h0);
      repeat (2) tick(1'b0, 1'b0, 24'h0, 24'h0);
    end

    // Constant pair offered continuously.
    repeat (12) begin
      tick(1'b1, 1'b1, 24'h123456, 24'hABCDEF);
      repeat (3) tick(1'b0, 1'b1, 24'h123456, 24'hABCDEF);
    end

    // Random stream with sparse and back-to-back acks; cs_cfg changes mid-run.
    cs_cfg = 32'h00000004;
    for (int i = 0; i < 2400; i++) begin
      if (i == 1300) cs_cfg = $urandom;
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 24'($urandom), 24'($urandom));
    end

    // Ack every cycle for two full blocks with a CRC-relevant configuration.
    cs_cfg = 32'h02000004;
    for (int i = 0; i < 800; i++)
      tick(1'b1, $urandom_range(0, 3) != 0, 24'($urandom), 24'($urandom));

    // Reset asserted while frame 100's right word is presented.
    guard = 0;
    while (m_widx != 201 && guard < 1000) begin
      tick(1'b1, $urandom_range(0, 1) == 1, 24'($urandom), 24'($urandom));
      guard++;
    end
    if (guard >= 1000) begin
      n_checks++;
      $display("FAIL reach_frame100_right: actual word %0d required 201", m_widx);
    end
    tick(1'b0, 1'b0, 24'h0, 24'h0);
    rst = 1'b1;
    repeat (2) tick(1'b0, 1'b1, 24'($urandom), 24'($urandom));
    rst = 1'b0;
    tick(1'b0, 1'b0, 24'h0, 24'h0);
    for (int i = 0; i < 40; i++)
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 24'($urandom), 24'($urandom));

    stim_done = 1'b1;
    chk("scoreboard_drain", 27'(expq.size()), 27'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spdif_word_gen.md
# spdif_word_gen

Subframe word generator feeding the SPDIF TX biphase coder. Accepts stereo 24-bit sample pairs over a valid/ready handshake and tracks the 192-frame channel-status block. Each word it presents is a 2-bit preamble code plus a 27-bit payload (audio, V, U, C). The coder appends parity and performs biphase coding; it pops each word with a one-cycle `word_ack`.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous reset, active-high
- `in_l`  in  24  left sample, two's complement, bit 0 = LSB
- `in_r`  in  24  right sample
- `in_valid`  in  1  sample pair offered
- `in_ready`  out  1  holding slot empty; pair accepted when `in_valid & in_ready`
- `cs_cfg`  in  32  channel-status bits 0..31, sampled at each block start
- `word_preamble`  out  2  00=B (frame 0 left), 10=M (left), 11=W (right)
- `word_payload`  out  27  [23:0] audio, [24] V, [25] U, [26] C
- `word_ack`  in  1  coder consumed current word this cycle
- `stat_underrun`  out  1  one-cycle pulse: frame built without a sample pair
- `stat_block`  out  1  one-cycle pulse: frame-0 left word built

## Operation
- State: `PRIME` (one cycle after reset) → `RUN`. `sub` (0=left, 1=right), `frame` 0..191, one-pair holding register (`hold_full`), current right sample register, 32-bit `cs_snap`.
- `PRIME`: builds frame-0 left word as below, then enters `RUN`. `word_ack` is ignored in `PRIME`.
- Build-left (frame f): if `hold_full`, take the pair, clear `hold_full`, set audio=`l`, V=0, and store `r`. Otherwise audio=0 and V=1, store right=0 with right-V=1, and pulse `stat_underrun`. Preamble is 00 if f==0, else 10.
- Build-right: audio=stored right, V=stored right-V, preamble=11.
- U=0 always. C for frame f is the same on both subframes:
  - f<32: `cs_snap[f]`. At f==0, `cs_cfg` is sampled into `cs_snap` and `cs_cfg[0]` is used directly.
  - 32≤f≤183: 0.
  - 184≤f≤191: see Configuration.
- On `word_ack` in `RUN`:
  - `sub==0`: Build-right, set `sub=1`.
  - `sub==1`: `frame = (frame==191) ? 0 : frame+1`, Build-left of the new frame, set `sub=0`.
- `stat_block` pulses in the cycle the frame-0 left word is loaded, including the `PRIME` load.
- Input side: `in_ready = ~hold_full` (registered). An accept sets `hold_full`. Accept and pop never coincide: ready is 0 while full.

## Timing
- Reset values: `word_preamble=00`, `word_payload=27'h1000000` (V=1), `in_ready=0`, `stat_*=0`, `frame=0`, `sub=0`, `hold_full=0`, `cs_snap=0`.
- Cycle 1 after reset release: `PRIME` loads the frame-0 word and `in_ready=1`. A pair is never present during `PRIME`, so the first left subframe is always an underrun.
- Outputs are registered. New word appears the cycle after `word_ack`. `word_preamble` and `word_payload` are stable between acks.
- The coder acks every 64 bit-ack periods, so there is no throughput constraint. Back-to-back acks on consecutive cycles must still be handled correctly.
- `in_ready` rises the cycle after a pop.
- Reset mid-block: returns to `PRIME`. The held pair and any partial CRC are discarded.

## Configuration
- `SPDIF_WORD_GEN_CRC_EN` defined: CRCC per AES3 byte 23.
  - `crc` is set to 8'hFF when frame 0 is built.
  - For each frame 0..183, when its left word is built, with emitted C bit `b`: `fb = b ^ crc[7]`, then `crc = {crc[6:0],0} ^ (fb ? 8'h1D : 0)`.
  - Frame 184+k emits `crc[k]` for k=0..7, with `crc` frozen.
- Not defined: frames 184..191 emit C=0 and no CRC logic is built.

## Test plan
- Reset, no input, 4 word_acks → words: 00/1000000, 11/1000000, 10/1000000, 11/1000000. `stat_underrun` pulses at PRIME and at the third word.
- Offer `in_l=24'h123456`, `in_r=24'hABCDEF` continuously → the next left word payload is 27'h0123456 with preamble 10, the following right word is 27'h0ABCDEF with preamble 11, and `in_ready` drops for exactly the hold period.
- Stream 384 words → preamble 00 reappears at word 384, `stat_block` pulses once per 384 words, and `frame` wraps 191→0.
- `cs_cfg=32'h00000004` → C=1 only on both subframes of frame 2 each block. Changing `cs_cfg` mid-block has no effect until the next frame 0.
- With `SPDIF_WORD_GEN_CRC_EN`, `cs_cfg=32'h02000004` → C bits of frames 184..191 match the bench model of the stated polynomial/init. Without the macro they are all 0.
- Assert `rst` at frame 100, right subframe → outputs return to reset values and the next block starts at frame 0 with preamble 00.
